// File: rtl/bd_cache_pkg.sv
// -----------------------------------------------------------------------------
// bd_cache_pkg
// Shared constants and types for the BD-compressed cache request path.
//   LINE_W / TAG_W / WORD_W : line, tag and word-address widths
//   sched_state_t           : request scheduler FSM encoding
// -----------------------------------------------------------------------------
package bd_cache_pkg;

  localparam int LINE_W = 644;
  localparam int TAG_W  = 64;
  localparam int WORD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_FILL_REQ  = 3'd2,
    ST_FILL_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } sched_state_t;

endpackage : bd_cache_pkg

// File: rtl/bd_request_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: selects the first asserted request
// at or after the pointer position, wrapping modulo NREQ.
// Ports:
//   i_req   : request vector
//   i_ptr   : index that has highest priority this cycle
//   o_grant : one-hot grant (all zero when no request)
//   o_id    : encoded index of the grant
//   o_any   : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_id,
  output logic                    o_any
);

  localparam int ID_W  = $clog2(NREQ);
  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  localparam int SUM_W = ID_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [ID_W-1:0]  w_idx;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(i);
      if (w_sum >= SUM_W'(NREQ)) begin
        w_sum = w_sum - SUM_W'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[ID_W-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/bd_request_scheduler.sv
// -----------------------------------------------------------------------------
// bd_request_scheduler
// Sequences one read request at a time through the BD cache request filter.
// A round-robin grant latches the request, a single-cycle lookup samples the
// filter miss flag, misses trigger a line fill and a retried lookup, and a
// response with hit/error status is held until consumed.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   req_valid/tag/wordaddr      : per-requester read requests
//   req_ready                   : one-hot accept pulse (combinational)
//   flt_tag/wordaddr/con        : filter lookup, flt_cachemiss result
//   fill_valid/ready/tag, done  : line fill handshake and completion pulse
//   rsp_valid/ready/id/hit/err  : response channel
//   hit_count, miss_count       : saturating lookup statistics
// -----------------------------------------------------------------------------
module bd_request_scheduler
  import bd_cache_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int MAX_RETRY    = 1,
  parameter int FILL_TIMEOUT = 256,
  parameter int CNT_W        = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NREQ-1:0][WORD_W-1:0] req_wordaddr,
  output logic [NREQ-1:0]             req_ready,
  output logic [TAG_W-1:0]            flt_tag,
  output logic [WORD_W-1:0]           flt_wordaddr,
  output logic                        flt_con,
  input  logic                        flt_cachemiss,
  output logic                        fill_valid,
  input  logic                        fill_ready,
  output logic [TAG_W-1:0]            fill_tag,
  input  logic                        fill_done,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic                        rsp_hit,
  output logic                        rsp_err,
  output logic [CNT_W-1:0]            hit_count,
  output logic [CNT_W-1:0]            miss_count
);

  localparam int ID_W    = $clog2(NREQ);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TMO_W   = $clog2(FILL_TIMEOUT + 1);

  sched_state_t      r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [TAG_W-1:0]  r_tag;
  logic [WORD_W-1:0] r_wordaddr;
  logic [RETRY_W-1:0] r_retry;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_rsp_hit;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_gnt_id),
    .o_any   (w_any)
  );

  // Accept only while idle; the grant itself is the one-hot ready.
  assign req_ready    = (r_state == ST_IDLE) ? w_grant : '0;

  assign flt_tag      = r_tag;
  assign flt_wordaddr = r_wordaddr;
  assign flt_con      = (r_state == ST_LOOKUP);
  assign fill_valid   = (r_state == ST_FILL_REQ);
  assign fill_tag     = r_tag;
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_id       = r_id;
  assign rsp_hit      = r_rsp_hit;
  assign rsp_err      = r_rsp_err;
  assign hit_count    = r_hit_cnt;
  assign miss_count   = r_miss_cnt;

  // Scheduler FSM, request latch, retry/timeout tracking and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_tag      <= '0;
      r_wordaddr <= '0;
      r_retry    <= '0;
      r_tmo      <= '0;
      r_rsp_hit  <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_tag      <= req_tag[w_gnt_id];
            r_wordaddr <= req_wordaddr[w_gnt_id];
            r_id       <= w_gnt_id;
            r_retry    <= '0;
            r_tmo      <= '0;
            r_ptr      <= (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
            r_state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (!flt_cachemiss) begin
            r_hit_cnt <= sat_inc(r_hit_cnt);
            r_rsp_hit <= 1'b1;
            r_rsp_err <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            r_miss_cnt <= sat_inc(r_miss_cnt);
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              r_state <= ST_FILL_REQ;
            end else begin
              r_rsp_hit <= 1'b0;
              r_rsp_err <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_FILL_REQ: begin
          if (fill_ready) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_tmo   <= '0;
            r_state <= ST_FILL_WAIT;
          end
        end
        ST_FILL_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (fill_done) begin
            r_tmo   <= '0;
            r_state <= ST_LOOKUP;
          end else if (r_tmo == TMO_W'(FILL_TIMEOUT - 1)) begin
            r_rsp_hit <= 1'b0;
            r_rsp_err <= 1'b1;
            r_state   <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : bd_request_scheduler

// File: tb/tb_bd_request_scheduler.sv
module tb_bd_request_scheduler;

  localparam int NREQ         = 2;
  localparam int MAX_RETRY    = 1;
  localparam int FILL_TIMEOUT = 8;
  localparam int CNT_W        = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][63:0] req_tag;
  logic [NREQ-1:0][3:0]  req_wordaddr;
  logic [NREQ-1:0]       req_ready;
  logic [63:0]           flt_tag;
  logic [3:0]            flt_wordaddr;
  logic                  flt_con;
  logic                  flt_cachemiss;
  logic                  fill_valid;
  logic                  fill_ready;
  logic [63:0]           fill_tag;
  logic                  fill_done;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [0:0]            rsp_id;
  logic                  rsp_hit;
  logic                  rsp_err;
  logic [CNT_W-1:0]      hit_count;
  logic [CNT_W-1:0]      miss_count;

  always #5 clk = ~clk;

  // Filter model: 0 always hit, 1 always miss, 2 miss until a fill completes.
  logic [1:0] miss_mode;
  logic       filled;
  assign flt_cachemiss = (miss_mode == 2'd1) || ((miss_mode == 2'd2) && !filled);

  bd_request_scheduler #(
    .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .FILL_TIMEOUT(FILL_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag), .req_wordaddr(req_wordaddr),
    .req_ready(req_ready),
    .flt_tag(flt_tag), .flt_wordaddr(flt_wordaddr), .flt_con(flt_con),
    .flt_cachemiss(flt_cachemiss),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_tag(fill_tag),
    .fill_done(fill_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic        id;
    logic [63:0] tag;
    logic [3:0]  wa;
    logic [1:0]  mode;
    int          delay;   // fill_done this many cycles after fill handshake; 0 = never
    logic        hit;
    logic        err;
    int          hits;    // cumulative expected counters after the transaction
    int          misses;
    int          fills;
    int          cons;
  } vec_t;

  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  sb_q[$];   // {id, hit, err}
  logic [2:0]  mon_e;
  int          fill_delay = 0;
  int          fill_cnt   = 0;
  int          fills_seen = 0;
  int          con_cycles = 0;
  logic        pend       = 1'b0;
  logic [63:0] exp_fill_tag = 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Fill responder: accepts every fill at once, pulses fill_done after fill_delay.
  initial begin
    fill_ready = 1'b0;
    fill_done  = 1'b0;
    forever begin
      @(negedge clk);
      fill_ready = 1'b0;
      fill_done  = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          fill_cnt++;
          if (fill_delay > 0 && fill_cnt == fill_delay) begin
            fill_done = 1'b1;
            filled    = 1'b1;
            pend      = 1'b0;
          end
        end
        if (fill_valid) begin
          fill_ready = 1'b1;
          fills_seen++;
          chk("fill_tag", fill_tag, exp_fill_tag);
          pend     = 1'b1;
          fill_cnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor: pops one expectation per response handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        if (flt_con) con_cycles++;
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id=%0d hit=%0b err=%0b, none expected", rsp_id, rsp_hit, rsp_err);
          end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_fields{id,hit,err}", {61'd0, rsp_id, rsp_hit, rsp_err}, {61'd0, mon_e});
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Call at negedge; returns at (accept negedge)+1.
  task automatic wait_accept(output logic [1:0] g, output int c);
    logic found;
    found = 1'b0;
    g = '0;
    c = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready != '0) begin
        g = req_ready;
        found = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
    if (!found) bound_fail("wait_accept");
  endtask

  task automatic wait_fill_hs();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (fill_ready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) bound_fail("wait_fill_handshake");
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      bound_fail("wait_response");
      sb_q.delete();
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_flt_con", flt_con, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_flt_tag", flt_tag, 0);
    chk("rst_flt_wordaddr", flt_wordaddr, 0);
    chk("rst_fill_tag", fill_tag, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    miss_mode = 2'd0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    logic [1:0] g;
    int         c;
    @(negedge clk);
    miss_mode    = v.mode;
    filled       = 1'b0;
    pend         = 1'b0;
    fill_delay   = v.delay;
    exp_fill_tag = v.tag;
    fills_seen   = 0;
    con_cycles   = 0;
    sb_q.push_back({v.id, v.hit, v.err});
    req_valid         = '0;
    req_valid[v.id]   = 1'b1;
    req_tag[v.id]     = v.tag;
    req_wordaddr[v.id] = v.wa;
    wait_accept(g, c);
    chk("grant", {62'd0, g}, 64'd1 << v.id);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("lookup_con", flt_con, 1);
    chk("lookup_tag", flt_tag, v.tag);
    chk("lookup_wordaddr", flt_wordaddr, v.wa);
    if (v.mode == 2'd0) begin
      @(negedge clk);
      #1;
      chk("hit_latency_rsp_valid", rsp_valid, 1);
    end
    wait_drain();
    @(negedge clk);
    #1;
    chk("hit_count", hit_count, v.hits);
    chk("miss_count", miss_count, v.misses);
    chk("fill_count", fills_seen, v.fills);
    chk("flt_con_cycles", con_cycles, v.cons);
  endtask

  initial begin
    logic [1:0] g;
    int         c;
    int         k;
    int         seen;
    vec_t       v;

    reset        = 1'b1;
    req_valid    = '0;
    req_tag      = '0;
    req_wordaddr = '0;
    rsp_ready    = 1'b1;
    miss_mode    = 2'd0;
    filled       = 1'b0;

    //        id    tag                     wa    mode  dly  hit   err   H  M  F  C
    vecs[0] = '{1'b0, 64'hAAAAAAAAAAAAAAA0, 4'h0, 2'd0, 0, 1'b1, 1'b0, 1, 0, 0, 1};
    vecs[1] = '{1'b0, 64'hAAAAAAAAAAAAAAA0, 4'h0, 2'd2, 1, 1'b1, 1'b0, 2, 1, 1, 2};
    vecs[2] = '{1'b1, 64'h123456789ABCDEF0, 4'h5, 2'd1, 3, 1'b0, 1'b1, 2, 3, 1, 2};
    vecs[3] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 4'hF, 2'd2, 8, 1'b1, 1'b0, 3, 4, 1, 2};
    vecs[4] = '{1'b0, 64'h0123456789ABCDEF, 4'h3, 2'd2, 9, 1'b0, 1'b1, 3, 5, 1, 1};
    vecs[5] = '{1'b1, 64'hDEADBEEFCAFEF00D, 4'hA, 2'd0, 0, 1'b1, 1'b0, 4, 5, 0, 1};

    @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single transactions (hit, miss+fill, retry exhausted,
    // fill_done on the expiry cycle, fill_done one cycle too late).
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // Fill timeout: RESP exactly FILL_TIMEOUT cycles after entering FILL_WAIT.
    @(negedge clk);
    rsp_ready    = 1'b0;
    miss_mode    = 2'd2;
    filled       = 1'b0;
    pend         = 1'b0;
    fill_delay   = 0;
    exp_fill_tag = 64'h5555AAAA5555AAAA;
    sb_q.push_back({1'b0, 1'b0, 1'b1});
    req_tag[0]      = 64'h5555AAAA5555AAAA;
    req_wordaddr[0] = 4'h7;
    req_valid       = 2'b01;
    wait_accept(g, c);
    @(negedge clk);
    req_valid = '0;
    wait_fill_hs();
    k = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      k++;
      if (rsp_valid) break;
    end
    chk("timeout_cycles_to_resp", k, FILL_TIMEOUT + 1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      chk("timeout_rsp_err_held", {rsp_valid, rsp_err, rsp_hit}, 3'b110);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    #1;
    chk("timeout_miss_count", miss_count, 6);

    // Reset while in FILL_WAIT: outputs clear at once, no response follows.
    @(negedge clk);
    miss_mode    = 2'd2;
    filled       = 1'b0;
    pend         = 1'b0;
    fill_delay   = 0;
    exp_fill_tag = 64'h0F0F0F0F0F0F0F0F;
    sb_q.push_back({1'b1, 1'b1, 1'b0});
    req_tag[1]      = 64'h0F0F0F0F0F0F0F0F;
    req_wordaddr[1] = 4'h9;
    req_valid       = 2'b10;
    wait_accept(g, c);
    @(negedge clk);
    req_valid = '0;
    wait_fill_hs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || fill_valid || flt_con) seen++;
    end
    chk("no_activity_after_reset", seen, 0);
    v = '{1'b0, 64'h0000111122223333, 4'h1, 2'd0, 0, 1'b1, 1'b0, 1, 0, 0, 1};
    run_txn(v);

    // Fairness: both requesters held valid; first response stalled 5 cycles.
    do_reset();
    @(negedge clk);
    miss_mode = 2'd0;
    rsp_ready = 1'b0;
    for (int n = 0; n < 4; n++) sb_q.push_back({n[0], 1'b1, 1'b0});
    req_tag[0] = 64'h00000000000000A0;
    req_tag[1] = 64'h00000000000000B1;
    req_valid  = 2'b11;
    wait_accept(g, c);
    chk("fair_grant_0", g, 2'b01);
    repeat (2) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("stall_rsp_stable", {rsp_valid, rsp_id, rsp_hit, rsp_err}, 4'b1010);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_accept(g, c);
    chk("fair_grant_1", g, 2'b10);
    for (int n = 2; n < 4; n++) begin
      @(negedge clk);
      wait_accept(g, c);
      chk("fair_grant_alt", g, (n % 2 == 0) ? 2'b01 : 2'b10);
      chk("b2b_spacing", c, 2);
    end
    @(negedge clk);
    req_valid = '0;
    wait_drain();
    @(negedge clk);
    #1;
    chk("fair_hit_count", hit_count, 4);

    // Counter saturation at all-ones (CNT_W=4 -> 15).
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      v = '{n[0], 64'hC0DE000000000000 + 64'(n), 4'(n), 2'd0, 0, 1'b1, 1'b0,
            (n > 15) ? 15 : n, 0, 0, 1};
      run_txn(v);
    end
    for (int n = 1; n <= 8; n++) begin
      v = '{n[0], 64'hBAD0000000000000 + 64'(n), 4'h2, 2'd1, 1, 1'b0, 1'b1,
            15, (2 * n > 15) ? 15 : 2 * n, 1, 2};
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bd_request_scheduler
